// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control path: controller states,
// the register-control bundle and its canned settings.
package mips_pipe_pkg;

    typedef enum logic [1:0] {
        ST_DRAIN    = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_HALT     = 2'd3
    } pipe_state_t;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    localparam logic [31:0] NOP_WORD = 32'b0;

    // One load enable and one flush per pipeline register, plus the PC enable.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_DRAIN  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_FROZEN = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Load-use: hold PC and IF/ID, push a bubble into ID/EX, let the load advance.
    localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    // Taken branch: squash the two younger wrong-path instructions.
    localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    // Normal-flow decode when memory is not holding the pipeline.
    function automatic pipe_ctrl_t run_decode(input logic branch, input logic load_use);
        pipe_ctrl_t c;
        if (branch)
            c = CTRL_BRANCH;
        else if (load_use)
            c = CTRL_BUBBLE;
        else
            c = CTRL_RUN;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: the load in EX writes a register that
// the instruction in ID is about to read.
module hazard_detect
    import mips_pipe_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       hit
);

    logic rs_match;
    logic rt_match;

    assign rs_match = (ex_rt == id_rs);
    assign rt_match = id_uses_rt && (ex_rt == id_rt);

    // $zero is never really written, so a load targeting it creates no dependency.
    assign hit = ex_memread && (ex_rt != REG_ZERO) && (rs_match || rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the IF/ID, ID/EX and EX/MEM registers: load-use
// bubbles, branch squash, and a bounded freeze while data memory is busy.
module pipe_hazard_ctrl
    import mips_pipe_pkg::*;
#(
    parameter int S           = 32,
    parameter int MEM_TIMEOUT = 16,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic          id_uses_rt,
    input  logic          ex_memread,
    input  logic [4:0]    ex_rt,
    input  logic          ex_branch,
    input  logic          mem_req,
    input  logic          mem_ready,
    output logic          pc_en,
    output logic          ifid_en,
    output logic          idex_en,
    output logic          exmem_en,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          exmem_flush,
    output logic [CW-1:0] stall_cnt,
    output logic          mem_err,
    output pipe_state_t   fsm_state
);

    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT_VAL = WW'(MEM_TIMEOUT);

    if (MEM_TIMEOUT < 2 || S < 1) begin : g_param_check
        $error("pipe_hazard_ctrl: MEM_TIMEOUT must be >= 2 and S >= 1");
    end

    pipe_state_t   state;
    pipe_state_t   state_nx;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nx;
    logic [WW-1:0] wait_inc;
    logic          err_set;
    logic          load_use;
    pipe_ctrl_t    ctrl;

    hazard_detect u_hazard_detect (
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .hit        (load_use)
    );

    assign wait_inc = wait_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_DRAIN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        err_set  = 1'b0;
        ctrl     = CTRL_DRAIN;
        case (state)
            ST_DRAIN: begin
                state_nx = ST_RUN;
            end
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    ctrl     = CTRL_FROZEN;
                    wait_nx  = WW'(1);
                    state_nx = ST_MEM_WAIT;
                end else begin
                    ctrl = run_decode(ex_branch, load_use);
                end
            end
            ST_MEM_WAIT: begin
                // Branch/load-use held in the frozen stages are acted on at release.
                if (mem_ready) begin
                    ctrl     = run_decode(ex_branch, load_use);
                    wait_nx  = '0;
                    state_nx = ST_RUN;
                end else begin
                    ctrl    = CTRL_FROZEN;
                    wait_nx = wait_inc;
                    if (wait_inc == TIMEOUT_VAL) begin
                        err_set  = 1'b1;
                        state_nx = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                ctrl = CTRL_FROZEN;
            end
            default: begin
                state_nx = ST_DRAIN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_err <= 1'b0;
        end else if (err_set) begin
            mem_err <= 1'b1;
        end
    end

    // Counts frozen-PC cycles in normal operation; DRAIN is reset recovery, not a stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_en && state != ST_DRAIN && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign ifid_en     = ctrl.ifid_en;
    assign idex_en     = ctrl.idex_en;
    assign exmem_en    = ctrl.exmem_en;
    assign ifid_flush  = ctrl.ifid_flush;
    assign idex_flush  = ctrl.idex_flush;
    assign exmem_flush = ctrl.exmem_flush;
    assign fsm_state   = state;

endmodule
